// File: rtl/uart_stream_pkg.sv
// Shared types and constants for the UART word streamer.
// UART_STREAM_CHECKSUM_EN (optional) adds one checksum byte to every frame length.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    SHIFT,
    TRANSM_OVER
  } stream_state_t;

  // start + 8 data + stop
  localparam int UART_BITS = 10;

  function automatic int frame_bytes(input int word_bytes, input bit send_header);
    int n;
    n = word_bytes + (send_header ? 1 : 0);
`ifdef UART_STREAM_CHECKSUM_EN
    n = n + 1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: one start bit, eight data bits LSB first, one stop bit.
// A start request while a byte is on the line is ignored.
module uart_byte_tx
  import uart_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       byte_done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0]     clk_cnt;
  logic [3:0]           bit_idx;
  logic                 active;
  logic                 last_tick;
  logic [UART_BITS-2:0] bits;  // {stop, data}; start bit is driven directly

  assign last_tick = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_done = active && last_tick && (bit_idx == 4'(UART_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
    end else if (!active) begin
      clk_cnt <= '0;
      bit_idx <= '0;
      if (start) begin
        active <= 1'b1;
        tx     <= 1'b0;
      end
    end else if (last_tick) begin
      clk_cnt <= '0;
      if (bit_idx == 4'(UART_BITS - 1)) begin
        active <= 1'b0;
        tx     <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= bits[0];
      end
    end else begin
      clk_cnt <= clk_cnt + CNT_W'(1);
    end
  end

  // Bit register drains toward bit 0, refilling with stop-level ones.
  always_ff @(posedge clk) begin
    if (!active && start) begin
      bits <= {1'b1, byte_in};
    end else if (active && last_tick) begin
      bits <= {1'b1, bits[UART_BITS-2:1]};
    end
  end

endmodule

// File: rtl/uart_word_streamer.sv
// Buffered UART word transmitter: valid/ready word FIFO feeding framed 8N1 bytes.
// Define UART_STREAM_CHECKSUM_EN to append the XOR of the data bytes to each frame.
module uart_word_streamer
  import uart_stream_pkg::*;
#(
  parameter int         WORD_BYTES   = 6,
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 8,
  parameter bit         MSB_FIRST    = 1'b0,
  parameter bit         SEND_HEADER  = 1'b1,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WORD_BYTES*8-1:0]         in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx_out,
  output logic                            busy,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int WORD_W      = WORD_BYTES * 8;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam int FRAME_BYTES = frame_bytes(WORD_BYTES, SEND_HEADER);
  localparam int BCNT_W      = $clog2(FRAME_BYTES + 1);

  stream_state_t state, state_nxt;

  logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  logic [WORD_W-1:0] shreg;
  logic [BCNT_W-1:0] bytes_left;
  logic              is_header;
  logic              is_cksum;
  logic              is_data;
  logic [7:0]        data_byte;
  logic [7:0]        tx_byte;
  logic              byte_start;
  logic              byte_done;

  // Word FIFO: first-word fall-through, head read straight from the array
  assign in_ready   = !reset && (count != CNT_W'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = (state == LOAD);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_data;
  end

  // Frame sequencing: bytes_left counts down to zero on the final byte
  assign data_byte = MSB_FIRST ? shreg[WORD_W-1 -: 8] : shreg[7:0];
  assign is_header = SEND_HEADER && (bytes_left == BCNT_W'(FRAME_BYTES - 1));
  assign is_data   = !is_header && !is_cksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      bytes_left <= '0;
    end else if (state == LOAD) begin
      bytes_left <= BCNT_W'(FRAME_BYTES - 1);
    end else if (state == SHIFT) begin
      bytes_left <= bytes_left - BCNT_W'(1);
    end
  end

  // The header byte does not consume word data, so only data bytes shift.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= fifo_mem[rd_ptr];
    end else if ((state == SHIFT) && is_data) begin
      shreg <= MSB_FIRST ? (shreg << 8) : (shreg >> 8);
    end
  end

`ifdef UART_STREAM_CHECKSUM_EN
  logic [7:0] cksum;

  assign is_cksum = (bytes_left == '0);

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      cksum <= '0;
    end else if ((state == SEND) && is_data) begin
      cksum <= cksum ^ data_byte;
    end
  end
`else
  assign is_cksum = 1'b0;
`endif

  always_comb begin
    tx_byte = data_byte;
    if (is_header) begin
      tx_byte = HEADER_BYTE;
    end
`ifdef UART_STREAM_CHECKSUM_EN
    else if (is_cksum) begin
      tx_byte = cksum;
    end
`endif
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_start = 1'b0;
    unique case (state)
      IDLE:        if (count != '0) state_nxt = LOAD;
      LOAD:        state_nxt = SEND;
      SEND: begin
        byte_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:        if (byte_done) state_nxt = (bytes_left == '0) ? TRANSM_OVER : SHIFT;
      SHIFT:       state_nxt = SEND;
      TRANSM_OVER: state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == TRANSM_OVER);

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (byte_start),
    .byte_in  (tx_byte),
    .tx       (tx_out),
    .byte_done(byte_done)
  );

endmodule

// File: tb/tb_uart_word_streamer.sv
// Self-checking bench: a line decoder rebuilds bytes from tx_out and compares them
// with frames predicted from each accepted word; timing is checked from decoded edges.
module tb_uart_word_streamer;
  localparam int C = 4;
`ifdef UART_STREAM_CHECKSUM_EN
  localparam int FB = 8;
`else
  localparam int FB = 7;
`endif
  localparam int BYTE_CYC  = 10 * C;
  localparam int FRAME_CYC = FB * BYTE_CYC + (FB - 1) * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_a, reset_b;
  logic [47:0] in_data_a, in_data_b;
  logic        in_valid_a, in_valid_b;
  logic        in_ready_a, in_ready_b;
  logic        tx_a, tx_b, busy_a, busy_b, fd_a, fd_b;
  logic [2:0]  cnt_a;
  logic [3:0]  cnt_b;

  uart_word_streamer #(
    .WORD_BYTES(6), .CLKS_PER_BIT(C), .FIFO_DEPTH(4),
    .MSB_FIRST(1'b0), .SEND_HEADER(1'b1), .HEADER_BYTE(8'hA5)
  ) dut_a (
    .clk(clk), .reset(reset_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx_out(tx_a), .busy(busy_a), .frame_done(fd_a),
    .fifo_count(cnt_a)
  );

  uart_word_streamer #(
    .WORD_BYTES(6), .CLKS_PER_BIT(C), .FIFO_DEPTH(8),
    .MSB_FIRST(1'b1), .SEND_HEADER(1'b1), .HEADER_BYTE(8'hA5)
  ) dut_b (
    .clk(clk), .reset(reset_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx_out(tx_b), .busy(busy_b), .frame_done(fd_b),
    .fifo_count(cnt_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes a frame must carry for a given word
  logic [7:0] exp_q0[$], exp_q1[$], got_q0[$], got_q1[$];

  task automatic expect_frame(input int ch, input logic [47:0] w);
    logic [7:0] fr[$];
    logic [7:0] d;
    fr.push_back(8'hA5);
    for (int i = 0; i < 6; i++) begin
      d = (ch == 1) ? w[8*(5-i) +: 8] : w[8*i +: 8];
      fr.push_back(d);
    end
`ifdef UART_STREAM_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 6; i++) x = x ^ w[8*i +: 8];
      fr.push_back(x);
    end
`endif
    foreach (fr[i]) begin
      if (ch == 0) exp_q0.push_back(fr[i]);
      else         exp_q1.push_back(fr[i]);
    end
  endtask

  // Line decoder: samples each bit in its middle, records start-bit fall cycles
  bit         mon_act[2];
  int         mon_t[2];
  logic [7:0] mon_sh[2];
  bit         fd_prev[2];
  int         fd_cnt[2];
  int         start_q0[$];
  int         fd_q0[$];

  task automatic mon_step(input int ch, input logic tx, input logic rst);
    int bit_no;
    if (rst) begin
      mon_act[ch] = 1'b0;
    end else if (!mon_act[ch]) begin
      if (tx == 1'b0) begin
        mon_act[ch] = 1'b1;
        mon_t[ch]   = 0;
        if (ch == 0) start_q0.push_back(cyc);
      end
    end else begin
      mon_t[ch]++;
      if ((mon_t[ch] % C) == (C / 2)) begin
        bit_no = mon_t[ch] / C;
        if (bit_no == 0) begin
          check_val("start_bit", 64'(tx), 64'(0));
        end else if (bit_no <= 8) begin
          mon_sh[ch] = {tx, mon_sh[ch][7:1]};
        end else begin
          check_val("stop_bit", 64'(tx), 64'(1));
          if (ch == 0) got_q0.push_back(mon_sh[ch]);
          else         got_q1.push_back(mon_sh[ch]);
          mon_act[ch] = 1'b0;
        end
      end
    end
  endtask

  task automatic fd_step(input int ch, input logic fd, input logic bsy, input logic rst);
    if (!rst) begin
      if (fd_prev[ch]) begin
        check_val("fd_one_cycle", 64'(fd), 64'(0));
        check_val("busy_fall", 64'(bsy), 64'(0));
      end
      if (fd) begin
        fd_cnt[ch]++;
        if (ch == 0) fd_q0.push_back(cyc);
        check_val("busy_at_fd", 64'(bsy), 64'(1));
      end
    end
    fd_prev[ch] = (fd === 1'b1) && !rst;
  endtask

  always @(negedge clk) begin
    mon_step(0, tx_a, reset_a);
    mon_step(1, tx_b, reset_b);
    fd_step(0, fd_a, busy_a, reset_a);
    fd_step(1, fd_b, busy_b, reset_b);
  end

  function automatic logic [47:0] rand48();
    return {16'($urandom()), $urandom()};
  endfunction

  // Drive one word; acc returns the edge index at which it was accepted
  task automatic send_word(input int ch, input logic [47:0] w, output int acc);
    int n;
    logic rdy;
    n = 0;
    acc = -1;
    if (ch == 0) begin in_data_a = w; in_valid_a = 1'b1; end
    else         begin in_data_b = w; in_valid_b = 1'b1; end
    rdy = (ch == 0) ? in_ready_a : in_ready_b;
    while (!rdy && n < 5000) begin
      @(negedge clk);
      n++;
      rdy = (ch == 0) ? in_ready_a : in_ready_b;
    end
    if (!rdy) begin
      check_val("send_timeout", 64'(0), 64'(1));
    end else begin
      @(negedge clk);
      acc = cyc;
      expect_frame(ch, w);
    end
    if (ch == 0) begin in_valid_a = 1'b0; in_data_a = rand48(); end
    else         begin in_valid_b = 1'b0; in_data_b = rand48(); end
  endtask

  task automatic wait_fd(input int ch, input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt[ch] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fd_cnt[ch] < target) check_val("frame_timeout", 64'(fd_cnt[ch]), 64'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_bytes(input int ch, input string tag);
    if (ch == 0) begin
      check_val({tag, "_len"}, 64'(got_q0.size()), 64'(exp_q0.size()));
      while (got_q0.size() > 0 && exp_q0.size() > 0)
        check_val(tag, 64'(got_q0.pop_front()), 64'(exp_q0.pop_front()));
      got_q0.delete();
      exp_q0.delete();
    end else begin
      check_val({tag, "_len"}, 64'(got_q1.size()), 64'(exp_q1.size()));
      while (got_q1.size() > 0 && exp_q1.size() > 0)
        check_val(tag, 64'(got_q1.pop_front()), 64'(exp_q1.pop_front()));
      got_q1.delete();
      exp_q1.delete();
    end
  endtask

  initial begin
    int acc, bs, fqb, fb;
    logic [47:0] w;
    reset_a = 1'b1; reset_b = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    in_data_a = '0; in_data_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx", 64'(tx_a), 64'(1));
    check_val("rst_busy", 64'(busy_a), 64'(0));
    check_val("rst_count", 64'(cnt_a), 64'(0));
    check_val("rst_fd", 64'(fd_a), 64'(0));
    check_val("rst_tx_b", 64'(tx_b), 64'(1));
    reset_a = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 64'(in_ready_a), 64'(1));
    check_val("rst_ready_b", 64'(in_ready_b), 64'(1));

    // Single word, LSB first: latency, byte spacing and frame length
    bs = start_q0.size(); fqb = fd_q0.size(); fb = fd_cnt[0];
    send_word(0, 48'h0605_0403_0201, acc);
    wait_fd(0, fb + 1, 2000);
    repeat (20) @(negedge clk);
    check_val("sw_fd_once", 64'(fd_cnt[0]), 64'(fb + 1));
    check_val("sw_nbytes", 64'(start_q0.size() - bs), 64'(FB));
    if (start_q0.size() >= bs + FB && fd_q0.size() > fqb) begin
      check_val("sw_start_lat", 64'(start_q0[bs] - acc), 64'(3));
      check_val("sw_fd_lat", 64'(fd_q0[fqb] - start_q0[bs]), 64'(FRAME_CYC));
      for (int i = 0; i < FB - 1; i++)
        check_val("sw_byte_gap", 64'(start_q0[bs+i+1] - start_q0[bs+i]), 64'(BYTE_CYC + 2));
    end
    check_val("sw_idle_busy", 64'(busy_a), 64'(0));
    compare_bytes(0, "sw_byte");

    // Back-pressure with a 4-deep FIFO
    bs = start_q0.size(); fqb = fd_q0.size(); fb = fd_cnt[0];
    for (int k = 1; k <= 6; k++) begin
      send_word(0, rand48(), acc);
      if (k <= 5) check_val("bp_ready", 64'(in_ready_a), 64'(k < 5));
      if (k == 5) check_val("bp_count", 64'(cnt_a), 64'(4));
    end
    wait_fd(0, fb + 6, 6 * FRAME_CYC + 500);
    if (start_q0.size() >= bs + 6 * FB && fd_q0.size() >= fqb + 6) begin
      for (int j = 0; j < 5; j++)
        check_val("bp_frame_gap", 64'(start_q0[bs + FB*(j+1)] - fd_q0[fqb + j]), 64'(4));
    end
    compare_bytes(0, "bp_byte");

    // Random words with random idle gaps
    fb = fd_cnt[0];
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      send_word(0, rand48(), acc);
    end
    wait_fd(0, fb + 8, 8 * FRAME_CYC + 1000);
    compare_bytes(0, "rnd_byte");

    // Reset during the third byte with a second word still queued
    bs = start_q0.size(); fb = fd_cnt[0];
    send_word(0, rand48(), acc);
    send_word(0, rand48(), acc);
    begin
      int n;
      n = 0;
      while (start_q0.size() < bs + 3 && n < 1000) begin
        @(negedge clk);
        n++;
      end
    end
    check_val("rm_pre_tx", 64'(tx_a), 64'(0));
    check_val("rm_pre_count", 64'(cnt_a), 64'(1));
    reset_a = 1'b1;
    @(negedge clk);
    check_val("rm_tx", 64'(tx_a), 64'(1));
    check_val("rm_count", 64'(cnt_a), 64'(0));
    check_val("rm_busy", 64'(busy_a), 64'(0));
    @(negedge clk);
    reset_a = 1'b0;
    got_q0.delete();
    exp_q0.delete();
    repeat (80) @(negedge clk);
    check_val("rm_no_fd", 64'(fd_cnt[0]), 64'(fb));
    check_val("rm_flushed", 64'(start_q0.size()), 64'(bs + 3));
    bs = start_q0.size();
    send_word(0, rand48(), acc);
    wait_fd(0, fb + 1, 2000);
    if (start_q0.size() > bs) check_val("rm_new_lat", 64'(start_q0[bs] - acc), 64'(3));
    compare_bytes(0, "rm_new_byte");

    // Most significant byte first
    fb = fd_cnt[1];
    send_word(1, 48'h0605_0403_0201, acc);
    wait_fd(1, fb + 1, 2000);
    compare_bytes(1, "msb_byte");
    fb = fd_cnt[1];
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      w = rand48();
      send_word(1, w, acc);
    end
    wait_fd(1, fb + 3, 3 * FRAME_CYC + 500);
    compare_bytes(1, "msb_rnd_byte");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
